// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: debounced two-button LED pattern generator (chase, bounce, fill, blink)
module led_pattern_sequencer #(
    parameter int   N_LED      = 8,
    parameter int   W_CNT      = 23,
    parameter int   PERIOD     = 8388608,
    parameter int   W_DEB      = 18,
    parameter int   DEB_CYCLES = 240000,
    parameter logic LED_ON     = 1'b0,
    parameter logic TACT_ON    = 1'b0
) (
    input  logic             CLK_24MHz,
    input  logic             RST,
    input  logic             Tact1,
    input  logic             Tact2,
    output logic [N_LED-1:0] USER_LED,
    output logic [1:0]       mode,
    output logic             hold,
    output logic             tick
);
    localparam int PW = $clog2(N_LED + 1);
    localparam logic [PW-1:0] LAST = PW'(N_LED - 1);
    localparam logic [PW-1:0] FULL = PW'(N_LED);
    localparam logic [W_CNT-1:0] RELOAD = W_CNT'(PERIOD - 1);
    localparam logic [W_DEB-1:0] DEB_MAX = W_DEB'(DEB_CYCLES - 1);

    typedef enum logic {IDLE, RUN} phase_t;

    logic [1:0]       s1_q, s2_q, deb_q, deb_d, press;
    logic [W_DEB-1:0] cnt_q [2];
    logic [W_DEB-1:0] cnt_d [2];
    logic [W_CNT-1:0] pre_q, pre_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             up_q, up_d, hold_q, hold_d, tick_q, tick_d, step;
    logic [1:0]       mode_q, mode_d;
    phase_t           phase_q, phase_d;
    logic [N_LED-1:0] led_q, led_d, lit;

    always_ff @(posedge CLK_24MHz or posedge RST) begin
        if (RST) begin
            s1_q    <= {2{~TACT_ON}};
            s2_q    <= {2{~TACT_ON}};
            deb_q   <= {2{~TACT_ON}};
            cnt_q   <= '{default: '0};
            pre_q   <= RELOAD;
            pos_q   <= '0;
            up_q    <= 1'b1;
            hold_q  <= 1'b0;
            tick_q  <= 1'b0;
            mode_q  <= 2'd0;
            phase_q <= IDLE;
            led_q   <= {N_LED{~LED_ON}};
        end else begin
            s1_q    <= {Tact2, Tact1};
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        deb_d   = deb_q;
        press   = 2'b00;
        pos_d   = pos_q;
        up_d    = up_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        led_d   = led_q;
        lit     = '0;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = '0;
            if (s2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DEB_MAX) begin
                    deb_d[b] = s2_q[b];
                    press[b] = s2_q[b] == TACT_ON;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
        step   = !hold_q && pre_q == '0;
        pre_d  = hold_q ? pre_q : (step ? RELOAD : pre_q - 1'b1);
        tick_d = step && !press[0];
        hold_d = hold_q ^ press[1];
        if (press[0]) begin
            mode_d  = mode_q + 2'd1;
            pos_d   = '0;
            up_d    = 1'b1;
            phase_d = IDLE;
            pre_d   = RELOAD;
            led_d   = {N_LED{~LED_ON}};
        end else if (step) begin
            if (phase_q == IDLE) begin
                phase_d = RUN;
                pos_d   = mode_q == 2'd2 ? PW'(1) : '0;
            end else begin
                case (mode_q)
                    2'd0: pos_d = pos_q == LAST ? '0 : pos_q + 1'b1;
                    2'd1: begin
                        // reversing at an end skips straight to its neighbour so ends show once
                        if (up_q) begin
                            pos_d = pos_q == LAST ? pos_q - 1'b1 : pos_q + 1'b1;
                            up_d  = pos_q != LAST;
                        end else begin
                            pos_d = pos_q == '0 ? PW'(1) : pos_q - 1'b1;
                            up_d  = pos_q == '0;
                        end
                    end
                    2'd2: pos_d = pos_q == FULL ? '0 : pos_q + 1'b1;
                    default: pos_d = pos_q == '0 ? PW'(1) : '0;
                endcase
            end
            for (int i = 0; i < N_LED; i++)
                lit[i] = mode_q == 2'd3 ? pos_d == '0 : mode_q == 2'd2 ? PW'(i) < pos_d : PW'(i) == pos_d;
            led_d = lit ~^ {N_LED{LED_ON}};
        end
    end

    assign USER_LED = led_q;
    assign mode     = mode_q;
    assign hold     = hold_q;
    assign tick     = tick_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: random and directed button stimulus checked against a frame-count model
module tb_led_pattern_sequencer;
    localparam int NL = 4, P = 4, DEB = 3;

    logic          clk = 1'b0, rst = 1'b1, t1 = 1'b1, t2 = 1'b1;
    logic [NL-1:0] USER_LED;
    logic [1:0]    mode;
    logic          hold, tick;
    logic [2:0]    samp;
    int            total = 0, bad = 0;

    int            m_mode, m_n, m_el;
    bit            m_hold, m_tick, m_flip;
    logic [1:0]    m_deb, m_pr;
    logic [1:0]    hist [DEB+2];

    led_pattern_sequencer #(
        .N_LED(NL), .W_CNT(3), .PERIOD(P), .W_DEB(4), .DEB_CYCLES(DEB),
        .LED_ON(1'b0), .TACT_ON(1'b0)
    ) dut (
        .CLK_24MHz(clk), .RST(rst), .Tact1(t1), .Tact2(t2),
        .USER_LED(USER_LED), .mode(mode), .hold(hold), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) samp <= {rst, t2, t1};

    // pin-level frame after n ticks since the last restart (n=0: not yet started)
    function automatic logic [NL-1:0] frame(int md, int n);
        logic [NL-1:0] l = '0;
        int p;
        if (n > 0) begin
            case (md)
                0: l[(n-1) % NL] = 1'b1;
                1: begin
                    p = (n-1) % (2*NL-2);
                    l[p < NL ? p : 2*NL-2-p] = 1'b1;
                end
                2: for (int i = 0; i < n % (NL+1); i++) l[i] = 1'b1;
                default: l = (n % 2) ? '1 : '0;
            endcase
        end
        return ~l;
    endfunction

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst || samp[2]) begin
            m_mode = 0; m_n = 0; m_el = 0; m_hold = 0; m_tick = 0; m_deb = 2'b11;
            for (int i = 0; i < DEB+2; i++) hist[i] = 2'b11;
        end else begin
            for (int i = DEB+1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = samp[1:0];
            m_pr = 2'b00;
            for (int b = 0; b < 2; b++) begin
                m_flip = 1;
                for (int i = 2; i <= DEB+1; i++) if (hist[i][b] == m_deb[b]) m_flip = 0;
                if (m_flip) begin
                    m_deb[b] = ~m_deb[b];
                    m_pr[b] = m_deb[b] == 1'b0;
                end
            end
            m_tick = 0;
            if (m_pr[0]) begin
                m_mode = (m_mode + 1) % 4; m_n = 0; m_el = 0;
            end else if (!m_hold) begin
                m_el++;
                if (m_el % P == 0) begin m_tick = 1; m_n++; end
            end
            if (m_pr[1]) m_hold = !m_hold;
        end
        if (!rst) begin
            chk("model_led", 8'(USER_LED), 8'(frame(m_mode, m_n)));
            chk("model_mode", 8'(mode), 8'(m_mode));
            chk("model_hold", 8'(hold), 8'(m_hold));
            chk("model_tick", 8'(tick), 8'(m_tick));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(int b, logic v);
        if (b == 0) t1 = v; else t2 = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; t1 = 1'b1; t2 = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic press_btn(int b);
        drive(b, 1'b0); cyc(DEB + 4);
        drive(b, 1'b1); cyc(DEB + 4);
    endtask

    task automatic bouncy(int b);
        int t, a, c;
        t = 0;
        while (t < 20) begin
            a = $urandom_range(1, 2);
            c = $urandom_range(1, 2);
            drive(b, 1'b0); cyc(a);
            drive(b, 1'b1); cyc(c);
            t += a + c;
        end
        press_btn(b);
    endtask

    initial begin
        cyc(2);
        do_reset();
        cyc(3);
        chk("pre_tick_led", 8'(USER_LED), 8'h0f);
        chk("pre_tick", 8'(tick), 8'h0);
        cyc(1);
        chk("first_frame", 8'(USER_LED), 8'h0e);
        chk("first_tick", 8'(tick), 8'h1);
        cyc(4);
        chk("second_frame", 8'(USER_LED), 8'h0d);

        do_reset();
        cyc(10);
        t2 = 1'b0;
        cyc(2);
        chk("led2_lit", 8'(USER_LED), 8'h0b);
        cyc(3);
        chk("hold_on", 8'(hold), 8'h1);
        cyc(50);
        chk("held_led", 8'(USER_LED), 8'h0b);
        chk("held_tick", 8'(tick), 8'h0);
        t2 = 1'b1;
        cyc(10);
        t2 = 1'b0;
        cyc(5);
        chk("hold_off", 8'(hold), 8'h0);
        cyc(1);
        chk("resume_led3", 8'(USER_LED), 8'h07);
        chk("resume_tick", 8'(tick), 8'h1);
        t2 = 1'b1;
        cyc(10);

        do_reset();
        cyc(3);
        t1 = 1'b0;
        cyc(5);
        chk("collide_tick", 8'(tick), 8'h0);
        chk("collide_led", 8'(USER_LED), 8'h0f);
        chk("collide_mode", 8'(mode), 8'h1);
        t1 = 1'b1;
        cyc(4);
        chk("post_collide_tick", 8'(tick), 8'h1);
        chk("post_collide_led", 8'(USER_LED), 8'h0e);

        do_reset();
        bouncy(0);
        chk("bouncy_mode", 8'(mode), 8'h1);

        do_reset();
        press_btn(0);
        press_btn(0);
        cyc(9);
        chk("fill_mode", 8'(mode), 8'h2);
        #3 rst = 1'b1;
        #1;
        chk("async_led", 8'(USER_LED), 8'h0f);
        chk("async_mode", 8'(mode), 8'h0);
        chk("async_tick", 8'(tick), 8'h0);
        cyc(1);

        do_reset();
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 5))
                0: cyc($urandom_range(1, 12));
                1: press_btn(0);
                2: press_btn(1);
                3: bouncy($urandom_range(0, 1));
                4: begin
                    t1 = 1'b0; t2 = 1'b0; cyc(DEB + 4);
                    t1 = 1'b1; t2 = 1'b1; cyc(DEB + 4);
                end
                default: begin
                    repeat ($urandom_range(2, 8)) begin
                        t1 = 1'($urandom_range(0, 1));
                        t2 = 1'($urandom_range(0, 1));
                        cyc(1);
                    end
                    t1 = 1'b1; t2 = 1'b1;
                    cyc(DEB + 4);
                end
            endcase
        end
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
